// File: rtl/issueq_freelist_pkg.sv
// issueq_freelist_pkg: shared issue-queue sizing constants and the entry packet type
package issueq_freelist_pkg;
    localparam int SIZE_ISSUEQ     = 32;
    localparam int SIZE_ISSUEQ_LOG = $clog2(SIZE_ISSUEQ);
    localparam int DISPATCH_WIDTH  = 4;
    localparam int ISSUE_WIDTH     = 4;

    typedef struct packed {
        logic [SIZE_ISSUEQ_LOG-1:0] id;
        logic                       valid;
    } iqEntryPkt;
endpackage

// File: rtl/issueq_freelist_lane_rank_compact.sv
// lane_rank_compact: exclusive prefix popcount per lane plus the total count of set lanes
module lane_rank_compact #(
    parameter int W = 4,
    localparam int RW = $clog2(W + 1)
) (
    input  logic [W-1:0]         i_vec,
    output logic [W-1:0][RW-1:0] o_rank,
    output logic [RW-1:0]        o_total
);
    always_comb begin
        o_total = '0;
        for (int i = 0; i < W; i++) begin
            o_rank[i] = o_total;
            o_total   = o_total + RW'(i_vec[i]);
        end
    end
endmodule

// File: rtl/issueq_freelist.sv
// issueq_freelist: circular free list handing unique IQ entry IDs to dispatch lanes and reclaiming granted IDs
module issueq_freelist
    import issueq_freelist_pkg::*;
#(
    parameter int IQ_SIZE    = SIZE_ISSUEQ,
    parameter int DISPATCH_W = DISPATCH_WIDTH,
    parameter int ISSUE_W    = ISSUE_WIDTH,
    localparam int IDW = $clog2(IQ_SIZE)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush_i,
    input  logic                           dispatchReady_i,
    input  logic [DISPATCH_W-1:0]          dispatchLaneActive_i,
    input  logic [ISSUE_W-1:0]             grantValid_i,
    input  logic [ISSUE_W-1:0][IDW-1:0]    grantId_i,
    output logic [DISPATCH_W-1:0]          freeEntryValid_o,
    output logic [DISPATCH_W-1:0][IDW-1:0] freeEntryId_o,
    output logic [IDW:0]                   freeCnt_o,
    output logic                           iqFull_o
);
    localparam int DRW = $clog2(DISPATCH_W + 1);
    localparam int GRW = $clog2(ISSUE_W + 1);

    logic [IDW-1:0] r_mem [IQ_SIZE];
    logic [IDW-1:0] r_head, r_tail;
    logic [IDW:0]   r_cnt;

    logic [DISPATCH_W-1:0][DRW-1:0] w_drank;
    logic [DRW-1:0]                 w_dtot;
    logic [ISSUE_W-1:0][GRW-1:0]    w_grank;
    logic [GRW-1:0]                 w_gtot;
    logic [IDW:0]                   w_p, w_g, w_room, w_gacc;
    logic                           w_full, w_pop, w_ovf, w_dup;

    lane_rank_compact #(.W(DISPATCH_W)) u_drank (.i_vec(dispatchLaneActive_i), .o_rank(w_drank), .o_total(w_dtot));
    lane_rank_compact #(.W(ISSUE_W))    u_grank (.i_vec(grantValid_i), .o_rank(w_grank), .o_total(w_gtot));

    // Room left after this cycle's pop bounds how many grants can be reclaimed
    assign w_full = r_cnt < (IDW+1)'(w_dtot);
    assign w_pop  = dispatchReady_i && !w_full;
    assign w_p    = w_pop ? (IDW+1)'(w_dtot) : '0;
    assign w_g    = (IDW+1)'(w_gtot);
    assign w_room = (IDW+1)'(IQ_SIZE) - (r_cnt - w_p);
    assign w_ovf  = w_g > w_room;
    assign w_gacc = w_ovf ? w_room : w_g;

    always_comb begin
        for (int k = 0; k < DISPATCH_W; k++) begin
            freeEntryId_o[k]    = dispatchLaneActive_i[k] ? r_mem[r_head + IDW'(w_drank[k])] : '0;
            freeEntryValid_o[k] = dispatchLaneActive_i[k] && ((IDW+1)'(w_drank[k]) < r_cnt);
        end
        freeCnt_o = r_cnt;
        iqFull_o  = w_full;
    end

    always_comb begin
        w_dup = 1'b0;
        for (int a = 0; a < ISSUE_W; a++)
            for (int b = a + 1; b < ISSUE_W; b++)
                w_dup = w_dup || (grantValid_i[a] && grantValid_i[b] && grantId_i[a] == grantId_i[b]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush_i) begin
            for (int i = 0; i < IQ_SIZE; i++)
                r_mem[i] <= IDW'(i);
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= (IDW+1)'(IQ_SIZE);
        end else begin
            for (int j = 0; j < ISSUE_W; j++)
                if (grantValid_i[j] && ((IDW+1)'(w_grank[j]) < w_room))
                    r_mem[r_tail + IDW'(w_grank[j])] <= grantId_i[j];
            r_head <= r_head + IDW'(w_p);
            r_tail <= r_tail + IDW'(w_gacc);
            r_cnt  <= r_cnt - w_p + w_gacc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush_i) begin
            assert (!(dispatchReady_i && w_full)) else $error("issueq_freelist: dispatch while full");
            assert (!w_ovf) else $error("issueq_freelist: free list overflow, surplus grants dropped");
            assert (!w_dup) else $error("issueq_freelist: duplicate grant IDs in one cycle");
        end
    end
endmodule

// File: tb/tb_issueq_freelist.sv
// tb_issueq_freelist: directed and random checks of the free list against a queue-based reference model
module tb_issueq_freelist;
    import issueq_freelist_pkg::*;
    localparam int N = SIZE_ISSUEQ, IDW = SIZE_ISSUEQ_LOG, D = DISPATCH_WIDTH, I = ISSUE_WIDTH;

    logic clk = 0, reset = 1, flush = 0, ready = 0;
    logic [D-1:0] act = '0;
    logic [I-1:0] gv = '0;
    logic [I-1:0][IDW-1:0] gid = '0;
    logic [D-1:0] fv;
    logic [D-1:0][IDW-1:0] fid;
    logic [IDW:0] fcnt;
    logic full;
    int n_cmp = 0, n_bad = 0;
    int fq[$], inf[$];

    always #5 clk = ~clk;

    issueq_freelist dut (
        .clk(clk), .reset(reset), .flush_i(flush), .dispatchReady_i(ready),
        .dispatchLaneActive_i(act), .grantValid_i(gv), .grantId_i(gid),
        .freeEntryValid_o(fv), .freeEntryId_o(fid), .freeCnt_o(fcnt), .iqFull_o(full)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        inf.delete();
        for (int i = 0; i < N; i++) fq.push_back(i);
    endtask

    task automatic check_model(string tag);
        int r = 0;
        chk({tag, ".cnt"}, 32'(fcnt), fq.size());
        chk({tag, ".full"}, 32'(full), 32'($countones(act) > fq.size()));
        for (int k = 0; k < D; k++) begin
            if (act[k]) begin
                chk($sformatf("%s.v%0d", tag, k), 32'(fv[k]), 32'(r < fq.size()));
                if (r < fq.size()) chk($sformatf("%s.id%0d", tag, k), 32'(fid[k]), fq[r]);
                r++;
            end else begin
                chk($sformatf("%s.v%0d", tag, k), 32'(fv[k]), 0);
                chk($sformatf("%s.id%0d", tag, k), 32'(fid[k]), 0);
            end
        end
    endtask

    task automatic model_update();
        if (flush) model_reset();
        else begin
            if (ready && $countones(act) <= fq.size())
                for (int k = 0; k < $countones(act); k++) inf.push_back(fq.pop_front());
            for (int j = 0; j < I; j++) if (gv[j]) fq.push_back(int'(gid[j]));
        end
    endtask

    task automatic cycle(string tag);
        #1 check_model(tag);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic take(int j, int id);
        int idx[$];
        gv[j]  = 1'b1;
        gid[j] = IDW'(id);
        idx = inf.find_first_index(x) with (x == id);
        if (idx.size() > 0) inf.delete(idx[0]);
    endtask

    task automatic idle();
        act = '0; ready = 0; gv = '0; flush = 0;
    endtask

    task automatic async_rst();
        idle();
        #2 reset = 1;
        #1 chk("arst.cnt", 32'(fcnt), N);
        #1 reset = 0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        act = D'($urandom);
        ready = ($urandom_range(0, 3) != 0) && ($countones(act) <= fq.size());
        gv = '0;
        for (int j = 0; j < I; j++)
            if ($urandom_range(0, 1) == 1 && inf.size() > 0) begin
                int p = $urandom_range(0, inf.size() - 1);
                gv[j]  = 1'b1;
                gid[j] = IDW'(inf[p]);
                inf.delete(p);
            end
        flush = ($urandom_range(0, 63) == 0);
    endtask

    initial begin
        int e5[4] = '{0, 1, 2, 4};
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1 chk("rst.cnt", 32'(fcnt), N);
        chk("rst.full", 32'(full), 0);

        // all four lanes drain the list in order
        act = '1; ready = 1;
        for (int c = 0; c < 8; c++) begin
            #1 for (int k = 0; k < D; k++) chk($sformatf("t1.c%0d.id%0d", c, k), 32'(fid[k]), 4 * c + k);
            cycle("t1");
        end
        ready = 0;
        #1 chk("t1.empty.cnt", 32'(fcnt), 0);
        chk("t1.empty.full", 32'(full), 1);

        act = '0;
        take(0, 7);
        take(2, 3);
        cycle("t3a");
        gv = '0; act = 4'b0011; ready = 1;
        #1 chk("t3.id0", 32'(fid[0]), 7);
        chk("t3.id1", 32'(fid[1]), 3);
        chk("t3.cnt", 32'(fcnt), 2);
        chk("t3.full", 32'(full), 0);
        cycle("t3b");

        // pop of 4 alongside a push of 3: pushed IDs wait for the next cycle
        idle();
        for (int j = 0; j < 4; j++) take(j, e5[j]);
        cycle("t5a");
        gv = '0; act = '1; ready = 1;
        take(0, 8); take(1, 9); take(2, 10);
        #1 chk("t5.cnt", 32'(fcnt), 4);
        for (int k = 0; k < D; k++) chk($sformatf("t5.id%0d", k), 32'(fid[k]), e5[k]);
        cycle("t5b");
        idle(); act = '1;
        #1 chk("t5.after.cnt", 32'(fcnt), 3);
        chk("t5.after.full", 32'(full), 1);
        for (int k = 0; k < 3; k++) chk($sformatf("t5.after.id%0d", k), 32'(fid[k]), 8 + k);
        chk("t5.after.v3", 32'(fv[3]), 0);
        cycle("t5c");

        async_rst();
        act = 4'b0101; ready = 1;
        #1 chk("t2.id0", 32'(fid[0]), 0);
        chk("t2.id2", 32'(fid[2]), 1);
        chk("t2.v1", 32'(fv[1]), 0);
        chk("t2.v3", 32'(fv[3]), 0);
        cycle("t2a");
        act = '1; ready = 0;
        #1 chk("t2.head", 32'(fid[0]), 2);
        cycle("t2b");

        for (int c = 0; c < 20; c++) begin
            rand_inputs();
            flush = 0;
            cycle("t6pre");
        end
        rand_inputs();
        flush = 1;
        cycle("t6f");
        idle(); act = '1;
        #1 chk("t6.cnt", 32'(fcnt), N);
        for (int k = 0; k < D; k++) chk($sformatf("t6.id%0d", k), 32'(fid[k]), k);
        cycle("t6b");

        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 299) == 0) async_rst();
            rand_inputs();
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
